// File: rtl/drum_voice_gen.sv
// Five-voice tone-burst generator driven by sequencer trigger levels.
// Optional DRUM_VOICE_RETRIG_EN: a trigger during a burst restarts it.
module drum_voice #(
  parameter int unsigned HP        = 8,
  parameter int unsigned BURST_LEN = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic playing,
  input  logic trig,
  output logic busy,
  output logic sq,
  output logic sq_nxt
);
`ifdef DRUM_VOICE_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SOUND = 1'b1;
  localparam logic [15:0] PCNT_INIT = 16'(HP - 1);
  localparam logic [7:0]  HCNT_INIT = 8'(BURST_LEN - 1);

  logic [0:0]  state, state_n;
  logic        prev;
  logic [15:0] pcnt, pcnt_n;
  logic [7:0]  hcnt, hcnt_n;
  logic        ev;

  assign ev     = trig & ~prev & playing;
  assign busy   = (state == S_SOUND);

  always_comb begin
    state_n = state;
    pcnt_n  = pcnt;
    hcnt_n  = hcnt;
    sq_nxt  = sq;
    if (!playing) begin
      state_n = S_IDLE;
      sq_nxt  = 1'b0;
    end else if (ev && (state == S_IDLE || RETRIG)) begin
      state_n = S_SOUND;
      pcnt_n  = PCNT_INIT;
      hcnt_n  = HCNT_INIT;
      sq_nxt  = 1'b1;
    end else if (state == S_SOUND) begin
      if (pcnt != 16'd0) begin
        pcnt_n = pcnt - 16'd1;
      end else if (hcnt != 8'd0) begin
        sq_nxt = ~sq;
        pcnt_n = PCNT_INIT;
        hcnt_n = hcnt - 8'd1;
      end else begin
        state_n = S_IDLE;
        sq_nxt  = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
      prev  <= 1'b0;
      pcnt  <= '0;
      hcnt  <= '0;
      sq    <= 1'b0;
    end else begin
      state <= state_n;
      prev  <= trig;
      pcnt  <= pcnt_n;
      hcnt  <= hcnt_n;
      sq    <= sq_nxt;
    end
  end
endmodule

module drum_voice_gen #(
  parameter int unsigned HP_A      = 8,
  parameter int unsigned HP_B      = 12,
  parameter int unsigned HP_C      = 16,
  parameter int unsigned HP_D      = 20,
  parameter int unsigned HP_E      = 24,
  parameter int unsigned BURST_LEN = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       playing,
  input  logic       Ain,
  input  logic       Bin,
  input  logic       Cin,
  input  logic       Din,
  input  logic       Ein,
  output logic [4:0] busy,
  output logic [4:0] sq,
  output logic [2:0] mix,
  output logic       audio
);
  localparam int NUM_VOICES = 5;
  localparam logic [NUM_VOICES-1:0][15:0] HP_VEC =
    {16'(HP_E), 16'(HP_D), 16'(HP_C), 16'(HP_B), 16'(HP_A)};

  logic [NUM_VOICES-1:0] trig, sq_nxt;
  logic [2:0]            mix_n;

  assign trig = {Ein, Din, Cin, Bin, Ain};

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    drum_voice #(
      .HP        (int'(HP_VEC[g])),
      .BURST_LEN (BURST_LEN)
    ) u_voice (
      .Clk     (Clk),
      .Reset   (Reset),
      .playing (playing),
      .trig    (trig[g]),
      .busy    (busy[g]),
      .sq      (sq[g]),
      .sq_nxt  (sq_nxt[g])
    );
  end

  // mix/audio come from next-state sq so they line up with the sq register
  always_comb begin
    mix_n = '0;
    for (int i = 0; i < NUM_VOICES; i++) mix_n = mix_n + {2'b00, sq_nxt[i]};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mix   <= '0;
      audio <= 1'b0;
    end else begin
      mix   <= mix_n;
      audio <= ^sq_nxt;
    end
  end
endmodule

// File: tb/tb_drum_voice_gen.sv
// Self-checking bench for drum_voice_gen: elapsed-time burst model plus directed literal checks.
module tb_drum_voice_gen;
  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       playing = 1'b0;
  logic [4:0] trig = '0;
  logic [4:0] busy, sq;
  logic [2:0] mix;
  logic       audio;

`ifdef DRUM_VOICE_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif
  localparam int BL = 8;
  int hp [5] = '{8, 12, 16, 20, 24};

  drum_voice_gen dut (
    .Clk(Clk), .Reset(Reset), .playing(playing),
    .Ain(trig[0]), .Bin(trig[1]), .Cin(trig[2]), .Din(trig[3]), .Ein(trig[4]),
    .busy(busy), .sq(sq), .mix(mix), .audio(audio)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_fail = 0;

  // Model: a voice is active for HP*BL cycles after its start edge; level from elapsed/HP parity.
  bit act [5];
  bit prv [5];
  int el  [5];

  task automatic chk(input string name, input int act_v, input int exp_v);
    n_chk++;
    if (act_v != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act_v, exp_v, $time);
    end
  endtask

  task automatic model_update();
    for (int v = 0; v < 5; v++) begin
      if (Reset) begin
        act[v] = 1'b0;
        prv[v] = 1'b0;
      end else begin
        bit ev;
        ev = trig[v] && !prv[v] && playing;
        if (!playing) act[v] = 1'b0;
        else if (act[v]) begin
          if (RETRIG && ev) el[v] = 0;
          else begin
            el[v]++;
            if (el[v] >= hp[v] * BL) act[v] = 1'b0;
          end
        end else if (ev) begin
          act[v] = 1'b1;
          el[v]  = 0;
        end
        prv[v] = trig[v];
      end
    end
  endtask

  task automatic compare();
    logic [4:0] eb, es;
    int em;
    eb = '0; es = '0; em = 0;
    for (int v = 0; v < 5; v++) begin
      eb[v] = act[v];
      es[v] = act[v] && ((el[v] / hp[v]) % 2 == 0);
      em += int'(es[v]);
    end
    chk("model_busy", int'(busy), int'(eb));
    chk("model_sq", int'(sq), int'(es));
    chk("model_mix", int'(mix), em);
    chk("model_audio", int'(audio), int'(^es));
  endtask

  task automatic step();
    @(posedge Clk);
    model_update();
    #1;
    compare();
  endtask

  task automatic pulse(input logic [4:0] m);
    trig = m;
    step();
    trig = '0;
  endtask

  initial begin
    int hi, sqh, rises;
    logic pb;
    int cnt [5];

    // reset
    Reset = 1'b1;
    step(); step();
    chk("reset_busy", int'(busy), 0);
    chk("reset_sq", int'(sq), 0);
    chk("reset_mix", int'(mix), 0);
    chk("reset_audio", int'(audio), 0);
    Reset = 1'b0;
    playing = 1'b1;
    step();

    // single trigger on A
    pulse(5'b00001);
    hi = int'(busy[0]); sqh = int'(sq[0]);
    repeat (69) begin
      step();
      hi += int'(busy[0]); sqh += int'(sq[0]);
    end
    chk("single_busy_len", hi, 64);
    chk("single_sq_high", sqh, 32);

    // held trigger fires once
    trig = 5'b00001;
    rises = 0; pb = 1'b0;
    repeat (200) begin
      step();
      if (busy[0] && !pb) rises++;
      pb = busy[0];
    end
    chk("held_one_burst", rises, 1);
    trig = '0; step();
    trig = 5'b00001; step();
    chk("held_refire", int'(busy[0]), 1);
    trig = '0;
    repeat (70) step();

    // simultaneous start
    pulse(5'b11111);
    chk("simul_busy", int'(busy), 31);
    chk("simul_mix5", int'(mix), 5);
    for (int v = 0; v < 5; v++) cnt[v] = int'(busy[v]);
    for (int i = 1; i < 200; i++) begin
      step();
      if (i == 7) chk("simul_mix5_end", int'(mix), 5);
      if (i == 8) chk("simul_mix4", int'(mix), 4);
      for (int v = 0; v < 5; v++) cnt[v] += int'(busy[v]);
    end
    chk("simul_len_a", cnt[0], 64);
    chk("simul_len_b", cnt[1], 96);
    chk("simul_len_c", cnt[2], 128);
    chk("simul_len_d", cnt[3], 160);
    chk("simul_len_e", cnt[4], 192);

    // stop mid-burst on C
    pulse(5'b00100);
    repeat (19) step();
    playing = 1'b0;
    step();
    chk("stop_busy", int'(busy), 0);
    chk("stop_sq", int'(sq), 0);
    chk("stop_mix", int'(mix), 0);
    pulse(5'b00100);
    repeat (3) step();
    chk("stop_ignore", int'(busy), 0);
    playing = 1'b1;
    repeat (3) step();
    chk("stop_resume_idle", int'(busy), 0);

    // retrigger 30 cycles into an A burst
    pulse(5'b00001);
    hi = int'(busy[0]);
    repeat (29) begin step(); hi += int'(busy[0]); end
    pulse(5'b00001);
    hi += int'(busy[0]);
    repeat (99) begin step(); hi += int'(busy[0]); end
    chk("retrig_len", hi, RETRIG ? 94 : 64);

    // reset mid-burst on E
    pulse(5'b10000);
    repeat (9) step();
    Reset = 1'b1;
    step();
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_mix", int'(mix), 0);
    chk("rst_mid_audio", int'(audio), 0);
    Reset = 1'b0;
    pulse(5'b10000);
    hi = int'(busy[4]);
    repeat (199) begin step(); hi += int'(busy[4]); end
    chk("rst_fresh_len", hi, 192);

    // randomized traffic against the model
    repeat (5000) begin
      for (int v = 0; v < 5; v++)
        if ($urandom_range(0, 11) == 0) trig[v] = ~trig[v];
      if ($urandom_range(0, 149) == 0) playing = ~playing;
      else if (!playing && $urandom_range(0, 9) == 0) playing = 1'b1;
      Reset = ($urandom_range(0, 599) == 0);
      step();
    end
    Reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
